svm_feature_loader: RTL and testbench
=====================================

// Module: svm_feature_loader
// PURPOSE
//   Upstream feeder for hw_svm. Buffers host feature words in a FIFO and frames them into
//   vectors of N_FEAT words. Streams each vector on hw_svm's test/test_valid/test_ready port.
//   After the last word of a vector it holds off until hw_svm completes its label handshake,
//   so only one vector is in flight inside hw_svm at a time.
// PARAMETERS
//   FEAT_W  32  feature word width (signed two's complement)
//   N_FEAT  8   feature words per vector (>=1)
//   DEPTH   16  FIFO depth in words (power of 2, >=2)
//   SHIFT   0   arithmetic right shift applied when SVM_FEAT_SCALE_EN is defined
// PORTS
//   clk          in   1       single clock, all state on posedge
//   rst          in   1       asynchronous, active-high reset
//   in_data      in   FEAT_W  signed feature word from host
//   in_valid     in   1       in_data valid
//   in_ready     out  1       FIFO can accept (= !full)
//   test         out  FEAT_W  signed feature word to hw_svm
//   test_valid   out  1       test valid
//   test_ready   in   1       hw_svm accepts test
//   label_valid  in   1       hw_svm label handshake, observed only
//   label_ready  in   1       label consumer ready, observed only
//   vec_count    out  16      vectors fully classified (label handshakes accepted)
//   proto_err    out  1       sticky: label handshake seen while not in WAIT_LABEL
// BEHAVIOUR
//   Reset values: FIFO empty; state FILL; feat_cnt=0; in_ready=1; test_valid=0; test=0;
//     vec_count=0; proto_err=0. Reset mid-vector flushes all buffered words. No partial vector survives.
//   Push: in_valid && in_ready. Pop: test_valid && test_ready.
//   FIFO: registered head (first-word-fall-through). A word pushed at edge k is visible on test
//     at edge k+1 at the earliest. No same-cycle bypass.
//   Full: in_ready=0 even if a pop occurs in the same cycle. Empty: test_valid=0.
//   Push and pop in the same cycle with the FIFO neither full nor empty: occupancy unchanged.
//   FSM FILL: test_valid = !empty. Each pop increments feat_cnt. A pop with feat_cnt==N_FEAT-1
//     resets feat_cnt to 0 and moves to WAIT_LABEL.
//   FSM WAIT_LABEL: test_valid=0 and the FIFO keeps accepting pushes.
//     On label_valid && label_ready: vec_count+1 (wraps 16'hFFFF->0), next state FILL.
//   A label handshake while in FILL sets proto_err, which holds until reset. FSM and counters are unaffected.
//   test is stable while test_valid=1 && !test_ready. Pointers wrap modulo DEPTH.
// CONFIGURATION
//   SVM_FEAT_SCALE_EN defined: the word entering the FIFO is (in_data >>> SHIFT), sign preserved,
//     truncated toward -inf. No added latency.
//   SVM_FEAT_SCALE_EN undefined: in_data is stored unmodified and SHIFT is ignored.
// STRUCTURE
//   svm_pkg: FEAT_W default constant, typedef logic signed [FEAT_W-1:0] feat_t,
//     typedef enum {FILL, WAIT_LABEL} loader_state_t.
//   Sub-module svm_fifo: parameterised FWFT FIFO (DEPTH, feat_t) with full/empty flags.
//     This top owns the FSM, feature counter, vec_count, proto_err and the optional scaler.
// TESTING
//   1 Reset, then push 'ha24e for one cycle with test_ready=1 -> test='ha24e, test_valid=1 one cycle later.
//     in_ready stays 1.
//   2 N_FEAT=8: push 8 words 1..8, test_ready=1 -> 8 pops in order, then test_valid=0.
//     Push a 9th word -> it stays in FIFO until label_valid&&label_ready, then vec_count=1.
//   3 test_ready=0, push 16 words -> in_ready=0 after the 16th push. A 17th push attempt is dropped.
//     Release test_ready -> words 1..16 emerge in order.
//   4 Label handshake pulse while in FILL -> proto_err=1 and sticky. vec_count unchanged.
//   5 Assert rst after 3 of 8 words popped with 5 buffered -> test_valid=0, in_ready=1, vec_count=0.
//     Next vector starts at feat_cnt=0.
//   6 SVM_FEAT_SCALE_EN, SHIFT=4: push -32 and 'ha24e -> test = -2 and 'h0a24.

Source files
------------

// File: rtl/svm_pkg.sv
// Shared types for the hw_svm feature loader: default word width, signed feature word
// type and the loader FSM state encoding.
// Imported by svm_fifo and svm_feature_loader.
package svm_pkg;

  localparam int FEAT_W_DEF = 32;
  localparam int VEC_CNT_W  = 16;

  typedef logic signed [FEAT_W_DEF-1:0] feat_t;

  typedef enum logic {
    FILL       = 1'b0,
    WAIT_LABEL = 1'b1
  } loader_state_t;

endpackage : svm_pkg

// File: rtl/svm_fifo.sv
// First-word-fall-through FIFO: head word is presented from the storage registers as soon
// as it is written (visible the cycle after the push edge, never bypassed).
// Pushes while full and pops while empty are ignored; the head reads as zero when empty.
import svm_pkg::*;

module svm_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = feat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     wr_data_i,
  input  logic pop_i,
  output T     rd_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes every buffered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule : svm_fifo

// File: rtl/svm_feature_loader.sv
// Frames buffered host feature words into N_FEAT-word vectors for hw_svm and holds off
// after each vector until hw_svm's label handshake completes (one vector in flight).
// Optional input scaler enabled by defining SVM_FEAT_SCALE_EN (arithmetic >>> SHIFT).
import svm_pkg::*;

module svm_feature_loader #(
  parameter int FEAT_W = FEAT_W_DEF,
  parameter int N_FEAT = 8,
  parameter int DEPTH  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [FEAT_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [FEAT_W-1:0] test,
  output logic                     test_valid,
  input  logic                     test_ready,
  input  logic                     label_valid,
  input  logic                     label_ready,
  output logic [VEC_CNT_W-1:0]     vec_count,
  output logic                     proto_err
);

  typedef logic signed [FEAT_W-1:0] word_t;

  localparam int CW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

`ifdef SVM_FEAT_SCALE_EN
  localparam bit SCALE_EN = 1'b1;
`else
  localparam bit SCALE_EN = 1'b0;
`endif
  // With scaling off the shift amount collapses to zero, so the word passes through untouched.
  localparam int SHAMT = SCALE_EN ? SHIFT : 0;

  loader_state_t   state_q;
  logic [CW-1:0]   feat_cnt_q;
  logic [VEC_CNT_W-1:0] vec_count_q;
  logic            proto_err_q;

  word_t           wr_word;
  word_t           head_word;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            label_hs;

  assign wr_word    = in_data >>> SHAMT;
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign test_valid = (state_q == FILL) && !fifo_empty;
  assign pop        = test_valid && test_ready;
  assign label_hs   = label_valid && label_ready;
  assign test       = head_word;
  assign vec_count  = vec_count_q;
  assign proto_err  = proto_err_q;

  svm_fifo #(
    .DEPTH (DEPTH),
    .T     (word_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (wr_word),
    .pop_i     (pop),
    .rd_data_o (head_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Vector framing FSM: count pops in FILL, park in WAIT_LABEL until the label handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      feat_cnt_q  <= '0;
      vec_count_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          // A label handshake here means hw_svm answered a vector we never finished.
          if (label_hs) proto_err_q <= 1'b1;
          if (pop) begin
            if (feat_cnt_q == CW'(N_FEAT - 1)) begin
              feat_cnt_q <= '0;
              state_q    <= WAIT_LABEL;
            end else begin
              feat_cnt_q <= feat_cnt_q + CW'(1);
            end
          end
        end
        WAIT_LABEL: begin
          if (label_hs) begin
            vec_count_q <= vec_count_q + VEC_CNT_W'(1);
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule : svm_feature_loader

// File: tb/tb_svm_feature_loader.sv
// Directed bench for svm_feature_loader with a queue-based reference model checked every
// cycle on the falling edge, plus literal expectations at key points of each scenario.
// Define SVM_FEAT_SCALE_EN for both DUT and bench to exercise the scaler (SHIFT=4).
module tb_svm_feature_loader;

  localparam int FEAT_W = 32;
  localparam int N_FEAT = 8;
  localparam int DEPTH  = 16;
`ifdef SVM_FEAT_SCALE_EN
  localparam int SHIFT  = 4;
`else
  localparam int SHIFT  = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [FEAT_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [FEAT_W-1:0] test;
  logic                     test_valid;
  logic                     test_ready;
  logic                     label_valid;
  logic                     label_ready;
  logic [15:0]              vec_count;
  logic                     proto_err;

  svm_feature_loader #(
    .FEAT_W (FEAT_W),
    .N_FEAT (N_FEAT),
    .DEPTH  (DEPTH),
    .SHIFT  (SHIFT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .test        (test),
    .test_valid  (test_valid),
    .test_ready  (test_ready),
    .label_valid (label_valid),
    .label_ready (label_ready),
    .vec_count   (vec_count),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: word queue, waiting flag, pops in current vector, label count, error flag.
  logic signed [31:0] mq[$];
  bit                 m_wait = 1'b0;
  int                 m_cnt  = 0;
  int                 m_vc   = 0;
  bit                 m_perr = 1'b0;

  function automatic logic signed [31:0] scale(input logic signed [31:0] x);
    return x >>> SHIFT;
  endfunction

  // Compare process: check outputs against the model, then apply the coming edge's effects.
  always @(negedge clk) begin : compare
    bit tv, m_push, m_pop, m_lbl, was_wait;
    if (rst) begin
      mq.delete();
      m_wait = 1'b0;
      m_cnt  = 0;
      m_vc   = 0;
      m_perr = 1'b0;
    end
    tv = !m_wait && (mq.size() > 0);
    check("in_ready", in_ready, 32'(mq.size() < DEPTH));
    check("test_valid", test_valid, 32'(tv));
    if (tv) check("test_data", test, mq[0]);
    check("vec_count", vec_count, 32'(m_vc));
    check("proto_err", proto_err, 32'(m_perr));
    if (!rst) begin
      m_push   = in_valid && (mq.size() < DEPTH);
      m_pop    = tv && test_ready;
      m_lbl    = label_valid && label_ready;
      was_wait = m_wait;
      if (m_lbl) begin
        if (was_wait) begin
          m_vc   = (m_vc + 1) % 65536;
          m_wait = 1'b0;
        end else begin
          m_perr = 1'b1;
        end
      end
      if (m_pop) begin
        void'(mq.pop_front());
        m_cnt++;
        if (m_cnt == N_FEAT) begin
          m_cnt  = 0;
          m_wait = 1'b1;
        end
      end
      if (m_push) mq.push_back(scale(in_data));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    test_ready  = 1'b0;
    label_valid = 1'b0;
    label_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic push_word(input logic signed [31:0] v);
    in_data  = v;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic label_pulse();
    label_valid = 1'b1;
    label_ready = 1'b1;
    cyc(1);
    label_valid = 1'b0;
    label_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    // 1: reset state, single word falls through one cycle after its push edge.
    do_reset();
    check("rst_test_valid", test_valid, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_test", test, 32'd0);
    check("rst_vec_count", vec_count, 32'd0);
    check("rst_proto_err", proto_err, 32'd0);
    test_ready = 1'b1;
    push_word(32'sh0000a24e);
    check("t1_test", test, 32'sh0000a24e >>> SHIFT);
    check("t1_test_valid", test_valid, 32'd1);
    check("t1_in_ready", in_ready, 32'd1);
    cyc(1);
    check("t1_drained", test_valid, 32'd0);

    // 2: one full vector, ninth word held until the label handshake.
    do_reset();
    test_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data  = i * 32'sd16;
      in_valid = 1'b1;
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(3);
    check("t2_wait_valid", test_valid, 32'd0);
    check("t2_wait_in_ready", in_ready, 32'd1);
    check("t2_wait_vc", vec_count, 32'd0);
    label_pulse();
    check("t2_vc", vec_count, 32'd1);
    check("t2_ninth_valid", test_valid, 32'd1);
    check("t2_ninth", test, (32'sd144) >>> SHIFT);
    cyc(1);
    check("t2_after_pop", test_valid, 32'd0);

    // 3: fill to DEPTH with the sink stalled, overflow attempt dropped, drain in order.
    do_reset();
    test_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      in_data  = 32'sh100 + i;
      in_valid = 1'b1;
      cyc(1);
    end
    check("t3_full", in_ready, 32'd0);
    in_data = 32'sd999;
    cyc(1);
    in_valid = 1'b0;
    check("t3_full_hold", in_ready, 32'd0);
    check("t3_head", test, 32'sh101 >>> SHIFT);
    test_ready = 1'b1;
    cyc(8);
    check("t3_wait", test_valid, 32'd0);
    check("t3_not_full", in_ready, 32'd1);
    label_pulse();
    check("t3_second_vec", test, 32'sh109 >>> SHIFT);
    check("t3_vc1", vec_count, 32'd1);
    cyc(8);
    label_pulse();
    check("t3_vc2", vec_count, 32'd2);

    // 4: label handshake while filling raises the sticky error only.
    test_ready = 1'b0;
    label_pulse();
    check("t4_perr", proto_err, 32'd1);
    check("t4_vc", vec_count, 32'd2);
    cyc(3);
    check("t4_perr_sticky", proto_err, 32'd1);

    // 5: reset mid-vector flushes everything and restarts the word count.
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(32'sh200 + i);
    test_ready = 1'b1;
    cyc(3);
    test_ready = 1'b0;
    check("t5_head", test, 32'sh204 >>> SHIFT);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", test_valid, 32'd0);
    check("t5_rst_in_ready", in_ready, 32'd1);
    check("t5_rst_vc", vec_count, 32'd0);
    cyc(1);
    rst = 1'b0;
    test_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data  = 32'sh300 + (i * 16);
      in_valid = 1'b1;
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(3);
    check("t5_wait", test_valid, 32'd0);
    label_pulse();
    check("t5_next", test, (32'sh300 + 32'sd144) >>> SHIFT);

`ifdef SVM_FEAT_SCALE_EN
    // 6: scaler keeps sign and rounds toward minus infinity.
    do_reset();
    push_word(-32'sd32);
    push_word(32'sh0000a24e);
    check("t6_neg", test, 32'hFFFFFFFE);
    test_ready = 1'b1;
    cyc(1);
    check("t6_pos", test, 32'h00000a24);
    test_ready = 1'b0;
`endif

    cyc(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_svm_feature_loader
